// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: register byte offsets within a block and the
// bit position of the fall half of the IRQ_EN / STATUS words.
package gpio_pkg;

    localparam logic [3:0] GPIO_IN_DATA   = 4'h0;
    localparam logic [3:0] GPIO_IN_IRQ_EN = 4'h4;
    localparam logic [3:0] GPIO_IN_STATUS = 4'h8;

    localparam int unsigned FALL_SHIFT = 16;

    typedef enum logic [1:0] {
        REG_DATA,
        REG_IRQ_EN,
        REG_STATUS,
        REG_NONE
    } gpio_in_reg_e;

    // Maps a byte offset inside the block to the register it selects.
    function automatic gpio_in_reg_e gpio_in_decode(input logic [3:0] offset);
        case (offset)
            GPIO_IN_DATA:   return REG_DATA;
            GPIO_IN_IRQ_EN: return REG_IRQ_EN;
            GPIO_IN_STATUS: return REG_STATUS;
            default:        return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO input bit: 2-FF synchroniser, stability counter and accepted level,
// with single-cycle rise/fall pulses coincident with the level update.
module gpio_debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    logic w_diff;
    logic w_accept;

    assign w_diff   = (r_sync2 != r_level);
    assign w_accept = w_diff && (r_cnt == LAST_CNT);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, which is what makes
    // r_sync1 -> r_sync2 a real two-stage synchroniser.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    // Counter is cleared on acceptance, so it never wraps.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (!w_diff) begin
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign level = r_level;
    assign rise  = w_accept &  r_sync2;
    assign fall  = w_accept & ~r_sync2;

endmodule

// File: rtl/gpio_in_capture.sv
// Memory-mapped GPIO input block: per-bit debounce, sticky W1C edge status,
// masked level interrupt and a zero-when-unselected read port for the bus OR mux.
module gpio_in_capture
    import gpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h2000_0010,
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wmask,
    output logic [31:0]      rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_level,
    output logic             irq
);

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_rise_st;
    logic [WIDTH-1:0] r_fall_st;

    logic             w_sel;
    gpio_in_reg_e     w_reg;
    logic             w_wr;
    logic             w_wr_irq_en;
    logic             w_wr_status;
    logic [WIDTH-1:0] w_clr_rise;
    logic [WIDTH-1:0] w_clr_fall;
    logic             w_unused;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            gpio_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_bit (
                .clk    (clk),
                .resetn (resetn),
                .din    (gpio_in[gi]),
                .level  (w_level[gi]),
                .rise   (w_rise[gi]),
                .fall   (w_fall[gi])
            );
        end
    endgenerate

    // Byte lanes are irrelevant: the block only supports full-word access.
    assign w_sel       = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign w_reg       = w_sel ? gpio_in_decode({mem_addr[3:2], 2'b00}) : REG_NONE;
    assign w_wr        = |mem_wmask;
    assign w_wr_irq_en = w_wr && (w_reg == REG_IRQ_EN);
    assign w_wr_status = w_wr && (w_reg == REG_STATUS);
    assign w_clr_rise  = w_wr_status ? mem_wdata[WIDTH-1:0]         : '0;
    assign w_clr_fall  = w_wr_status ? mem_wdata[FALL_SHIFT +: WIDTH] : '0;
    assign w_unused    = ^{mem_addr[1:0], mem_wdata};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (w_wr_irq_en) begin
            r_rise_en <= mem_wdata[WIDTH-1:0];
            r_fall_en <= mem_wdata[FALL_SHIFT +: WIDTH];
        end
    end

    // New edges are OR-ed in after the clear so a same-cycle edge wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rise_st <= '0;
            r_fall_st <= '0;
        end else begin
            r_rise_st <= (r_rise_st & ~w_clr_rise) | w_rise;
            r_fall_st <= (r_fall_st & ~w_clr_fall) | w_fall;
        end
    end

    // NOTE: rdata gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rdata = '0;
        case (w_reg)
            REG_DATA:   rdata = 32'(w_level);
            REG_IRQ_EN: rdata = 32'(r_rise_en) | (32'(r_fall_en) << FALL_SHIFT);
            REG_STATUS: rdata = 32'(r_rise_st) | (32'(r_fall_st) << FALL_SHIFT);
            default:    rdata = '0;
        endcase
    end

    assign gpio_level = w_level;
    assign irq        = |((r_rise_st & r_rise_en) | (r_fall_st & r_fall_en));

endmodule

// File: tb/tb_gpio_in_capture.sv
// Directed bench for gpio_in_capture with DEBOUNCE_CYCLES=4, WIDTH=8:
// pin-to-DATA latency is 6 clocks, so pulses of 3 and 4 clocks straddle the threshold.
module tb_gpio_in_capture;

    localparam logic [31:0] A_DATA   = 32'h2000_0010;
    localparam logic [31:0] A_IRQ_EN = 32'h2000_0014;
    localparam logic [31:0] A_STATUS = 32'h2000_0018;
    localparam logic [31:0] A_RSVD   = 32'h2000_001C;

    logic        clk;
    logic        resetn;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] rdata;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_level;
    logic        irq;

    int total = 0;
    int bad   = 0;

    gpio_in_capture #(
        .BASE_ADDR       (32'h2000_0010),
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .rdata      (rdata),
        .gpio_in    (gpio_in),
        .gpio_level (gpio_level),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        mem_addr  = addr;
        mem_wmask = 4'h0;
        #1;
        data = rdata;
    endtask

    // Write is presented for exactly one rising edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        mem_addr  = addr;
        mem_wdata = data;
        mem_wmask = 4'hF;
        tick(1);
        mem_wmask = 4'h0;
        mem_wdata = 32'h0;
    endtask

    task automatic expect_reg(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] got;
        bus_read(addr, got);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", name, got, exp);
        end
    endtask

    task automatic expect_irq(input string name, input logic exp);
        total++;
        if (irq !== exp) begin
            bad++;
            $display("FAIL %s: irq got=%b want=%b", name, irq, exp);
        end
    endtask

    task automatic test_reset();
        expect_reg("reset_data",   A_DATA,   32'h0);
        expect_reg("reset_irq_en", A_IRQ_EN, 32'h0);
        expect_reg("reset_status", A_STATUS, 32'h0);
        expect_reg("reset_rsvd",   A_RSVD,   32'h0);
        expect_irq("reset_irq", 1'b0);
        total++;
        if (gpio_level !== 8'h00) begin
            bad++;
            $display("FAIL reset_level: got=%02h want=00", gpio_level);
        end
    endtask

    task automatic test_rise_latency();
        gpio_in[0] = 1'b1;
        tick(5);
        expect_reg("rise_data_early", A_DATA, 32'h0);
        tick(1);
        expect_reg("rise_data_on_time", A_DATA, 32'h0000_0001);
        expect_reg("rise_status", A_STATUS, 32'h0000_0001);
        expect_irq("rise_irq_masked", 1'b0);
    endtask

    task automatic test_glitch();
        gpio_in[3] = 1'b1;
        tick(3);
        gpio_in[3] = 1'b0;
        tick(8);
        expect_reg("glitch3_data",   A_DATA,   32'h0000_0001);
        expect_reg("glitch3_status", A_STATUS, 32'h0000_0001);

        gpio_in[3] = 1'b1;
        tick(4);
        gpio_in[3] = 1'b0;
        tick(2);
        expect_reg("pulse4_data",   A_DATA,   32'h0000_0009);
        expect_reg("pulse4_status", A_STATUS, 32'h0000_0009);
        tick(6);
        expect_reg("pulse4_fall_data",   A_DATA,   32'h0000_0001);
        expect_reg("pulse4_fall_status", A_STATUS, 32'h0008_0009);
        bus_write(A_STATUS, 32'h0008_0008);
        expect_reg("pulse4_cleared", A_STATUS, 32'h0000_0001);
    endtask

    task automatic test_irq();
        bus_write(A_IRQ_EN, 32'hFFFF_FFFF);
        expect_reg("irq_en_unused_bits", A_IRQ_EN, 32'h00FF_00FF);
        expect_irq("irq_rise_enabled", 1'b1);
        bus_write(A_IRQ_EN, 32'h0001_0000);
        expect_reg("irq_en_fall0", A_IRQ_EN, 32'h0001_0000);
        expect_irq("irq_fall_only", 1'b0);

        gpio_in[0] = 1'b0;
        tick(6);
        expect_reg("fall_data",   A_DATA,   32'h0);
        expect_reg("fall_status", A_STATUS, 32'h0001_0001);
        expect_irq("fall_irq", 1'b1);
        expect_reg("unselected_read", 32'h2000_0028, 32'h0);

        bus_write(A_STATUS, 32'h0001_0000);
        expect_reg("w1c_status", A_STATUS, 32'h0000_0001);
        expect_irq("w1c_irq", 1'b0);
    endtask

    task automatic test_back_to_back();
        bus_write(A_STATUS, 32'h0000_0001);
        expect_reg("clear_before_race", A_STATUS, 32'h0);

        // Clear lands on the same edge that accepts the new rise.
        gpio_in[0] = 1'b1;
        tick(5);
        bus_write(A_STATUS, 32'h0000_0001);
        expect_reg("set_wins_status", A_STATUS, 32'h0000_0001);
        expect_reg("set_wins_data",   A_DATA,   32'h0000_0001);

        bus_write(A_DATA, 32'hFFFF_FFFF);
        bus_write(A_RSVD, 32'hFFFF_FFFF);
        expect_reg("ro_data",   A_DATA,   32'h0000_0001);
        expect_reg("ro_irq_en", A_IRQ_EN, 32'h0001_0000);
        expect_reg("ro_status", A_STATUS, 32'h0000_0001);
        expect_reg("ro_rsvd",   A_RSVD,   32'h0);
    endtask

    task automatic test_reset_mid_debounce();
        gpio_in[5] = 1'b1;
        tick(4);
        resetn = 1'b0;
        #2;
        expect_reg("midrst_data",   A_DATA,   32'h0);
        expect_reg("midrst_status", A_STATUS, 32'h0);
        expect_reg("midrst_irq_en", A_IRQ_EN, 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick(5);
        expect_reg("postrst_data_early", A_DATA, 32'h0);
        tick(1);
        // Pin 0 is still high from the previous test, so it is re-accepted too.
        expect_reg("postrst_data",   A_DATA,   32'h0000_0021);
        expect_reg("postrst_status", A_STATUS, 32'h0000_0021);
        expect_irq("postrst_irq", 1'b0);
    endtask

    initial begin
        resetn    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wmask = 4'h0;
        gpio_in   = 8'h00;
        tick(3);
        resetn = 1'b1;
        tick(1);

        test_reset();
        test_rise_latency();
        test_glitch();
        test_irq();
        test_back_to_back();
        test_reset_mid_debounce();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
